// File: rtl/clk_gen_pkg.sv
`default_nettype none
// ============================================================================
// clk_gen_pkg : shared controller state encoding and configuration clamp
// rev 1.0
// ============================================================================
package clk_gen_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOCKED = 2'd1,
    ST_UPDATE = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic [31:0] div;
    logic [31:0] high;
    logic [31:0] phase;
  } clamp_t;

  // High-time and phase are clamped against the already-clamped divide ratio.
  function automatic clamp_t clamp_cfg(input logic [31:0] div,
                                       input logic [31:0] high,
                                       input logic [31:0] phase);
    clamp_t r;
    r.div   = (div < 32'd2) ? 32'd2 : div;
    r.high  = (high == 32'd0) ? 32'd1 : high;
    if (r.high >= r.div) begin
      r.high = r.div - 32'd1;
    end
    r.phase = (phase >= r.div) ? (r.div - 32'd1) : phase;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// clk_div_chan : one divider channel -- config registers, counter, output flop
// rev 1.0
// ============================================================================
module clk_div_chan #(
  parameter int CNT_WIDTH   = 8,
  parameter int DIV_DEFAULT = 4
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 wr,
  input  logic [CNT_WIDTH-1:0] wr_div,
  input  logic [CNT_WIDTH-1:0] wr_high,
  input  logic [CNT_WIDTH-1:0] wr_phase,
  output logic                 outclk
);

  localparam int RST_HIGH_I = (DIV_DEFAULT / 2 > 0) ? (DIV_DEFAULT / 2) : 1;
  localparam logic [CNT_WIDTH-1:0] RST_DIV  = CNT_WIDTH'(DIV_DEFAULT);
  localparam logic [CNT_WIDTH-1:0] RST_HIGH = CNT_WIDTH'(RST_HIGH_I);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] div;
  logic [CNT_WIDTH-1:0] high;
  logic [CNT_WIDTH-1:0] phase;
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      div   <= RST_DIV;
      high  <= RST_HIGH;
      phase <= '0;
    end else if (wr) begin
      div   <= wr_div;
      high  <= wr_high;
      phase <= wr_phase;
    end
  end

  // A realign loads the phase that will be in force after this cycle.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= wr ? wr_phase : phase;
    end else if (cnt >= div - ONE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      outclk <= 1'b0;
    end else begin
      outclk <= (cnt < high);
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_divider_bank.sv
`default_nettype none
// ============================================================================
// clk_divider_bank : bank of programmable clock dividers with relock handshake
// rev 1.0
// ============================================================================
module clk_divider_bank
  import clk_gen_pkg::*;
#(
  parameter int  NUM_CLOCKS  = 2,
  parameter int  CNT_WIDTH   = 8,
  parameter int  LOCK_CYCLES = 16,
  parameter int  DIV_DEFAULT = 4,
  localparam int CHAN_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [CNT_WIDTH-1:0]  cfg_div,
  input  logic [CNT_WIDTH-1:0]  cfg_high,
  input  logic [CNT_WIDTH-1:0]  cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  ctrl_state_t state;
  ctrl_state_t state_nx;
  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] lock_cnt_nx;

  logic accept;
  logic upd;
  clamp_t cl;

  logic [CHAN_W-1:0]    pend_chan;
  logic [CNT_WIDTH-1:0] pend_div;
  logic [CNT_WIDTH-1:0] pend_high;
  logic [CNT_WIDTH-1:0] pend_phase;

  assign cfg_ready = locked;
  assign accept    = cfg_valid && locked;
  assign upd       = (state == ST_UPDATE);
  assign cl        = clamp_cfg(32'(cfg_div), 32'(cfg_high), 32'(cfg_phase));

  always_comb begin
    state_nx    = state;
    lock_cnt_nx = lock_cnt;
    case (state)
      ST_SETTLE: begin
        if (lock_cnt == LOCK_LAST) begin
          state_nx = ST_LOCKED;
        end else begin
          lock_cnt_nx = lock_cnt + LOCK_W'(1);
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          state_nx = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        lock_cnt_nx = '0;
        state_nx    = ST_SETTLE;
      end
      default: begin
        lock_cnt_nx = '0;
        state_nx    = ST_SETTLE;
      end
    endcase
  end

  // locked comes straight from a flop so it cannot glitch on state decode.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state    <= ST_SETTLE;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nx;
      lock_cnt <= lock_cnt_nx;
      locked   <= (state_nx == ST_LOCKED);
    end
  end

  // The request is captured at the handshake so the inputs may move during UPDATE.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pend_chan  <= '0;
      pend_div   <= '0;
      pend_high  <= '0;
      pend_phase <= '0;
    end else if (accept) begin
      pend_chan  <= cfg_chan;
      pend_div   <= CNT_WIDTH'(cl.div);
      pend_high  <= CNT_WIDTH'(cl.high);
      pend_phase <= CNT_WIDTH'(cl.phase);
    end
  end

  // An out-of-range channel index matches no instance, so only the realign happens.
  for (genvar n = 0; n < NUM_CLOCKS; n++) begin : g_chan
    clk_div_chan #(
      .CNT_WIDTH   (CNT_WIDTH),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_chan (
      .refclk   (refclk),
      .rst      (rst),
      .load     (upd),
      .wr       (upd && (pend_chan == CHAN_W'(n))),
      .wr_div   (pend_div),
      .wr_high  (pend_high),
      .wr_phase (pend_phase),
      .outclk   (outclk[n])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_divider_bank.sv
`default_nettype none
// Randomized bench for clk_divider_bank against a cycle-level behavioural model.
module tb_clk_divider_bank;

  localparam int NCH  = 3;
  localparam int CW   = 2;
  localparam int W    = 8;
  localparam int LOCK = 16;
  localparam int DIVD = 4;

  logic           refclk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_chan = '0;
  logic [W-1:0]   cfg_div = '0;
  logic [W-1:0]   cfg_high = '0;
  logic [W-1:0]   cfg_phase = '0;
  logic [NCH-1:0] outclk;
  logic           locked;

  int total = 0;
  int bad   = 0;

  clk_divider_bank #(
    .NUM_CLOCKS  (NCH),
    .CNT_WIDTH   (W),
    .LOCK_CYCLES (LOCK),
    .DIV_DEFAULT (DIVD)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  // Reference model: per-channel position within its period, plus a countdown to lock.
  int m_div[NCH], m_high[NCH], m_phase[NCH], m_pos[NCH];
  logic [NCH-1:0] m_out;
  bit m_locked, m_upd;
  int m_wait, p_chan, p_div, p_high, p_phase;

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_div[c]   = DIVD;
        m_high[c]  = (DIVD / 2 > 0) ? DIVD / 2 : 1;
        m_phase[c] = 0;
        m_pos[c]   = 0;
      end
      m_out = '0;
      m_locked = 0;
      m_upd = 0;
      m_wait = LOCK;
    end else begin
      for (int c = 0; c < NCH; c++) m_out[c] = (m_pos[c] < m_high[c]);
      if (m_upd) begin
        if (p_chan < NCH) begin
          m_div[p_chan]   = p_div;
          m_high[p_chan]  = p_high;
          m_phase[p_chan] = p_phase;
        end
        for (int c = 0; c < NCH; c++) m_pos[c] = m_phase[c];
        m_upd = 0;
      end else begin
        for (int c = 0; c < NCH; c++) m_pos[c] = (m_pos[c] + 1) % m_div[c];
      end
      if (m_locked && cfg_valid) begin
        p_chan  = int'(cfg_chan);
        p_div   = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
        p_high  = (cfg_high == 0) ? 1 : int'(cfg_high);
        if (p_high > p_div - 1) p_high = p_div - 1;
        p_phase = (int'(cfg_phase) > p_div - 1) ? p_div - 1 : int'(cfg_phase);
        m_upd    = 1;
        m_locked = 0;
        m_wait   = LOCK + 1;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_locked = 1;
      end
    end
  end

  task automatic wait_locked(output int n);
    n = 0;
    while (locked !== 1'b1 && n < 200) begin
      @(negedge refclk);
      n++;
    end
  endtask

  task automatic issue(input int chan, input int div, input int high, input int phase);
    cfg_chan  = CW'(chan);
    cfg_div   = W'(div);
    cfg_high  = W'(high);
    cfg_phase = W'(phase);
    cfg_valid = 1'b1;
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(negedge refclk);
    total++;
    if (outclk !== '0) begin bad++; $display("FAIL reset_outclk: got %b want 0", outclk); end
    total++;
    if ({locked, cfg_ready} !== 2'b00) begin bad++; $display("FAIL reset_lock: got %b want 00", {locked, cfg_ready}); end
    rst = 1'b0;
    n = 0;
    while (locked !== 1'b1 && n < 100) begin
      @(negedge refclk);
      n++;
      total++;
      if ({outclk, locked, cfg_ready} !== {m_out, m_locked, m_locked}) begin
        bad++; $display("FAIL reset_model: got %b want %b", {outclk, locked, cfg_ready}, {m_out, m_locked, m_locked});
      end
    end
    total++;
    if (n != LOCK) begin bad++; $display("FAIL reset_lock_delay: got %0d want %0d", n, LOCK); end
  endtask

  task automatic test_defaults();
    int h0 = 0, h1 = 0;
    repeat (16) begin
      @(negedge refclk);
      h0 += outclk[0];
      h1 += outclk[1];
      total++;
      if ({outclk, locked, cfg_ready} !== {m_out, m_locked, m_locked}) begin
        bad++; $display("FAIL defaults_model: got %b want %b", {outclk, locked, cfg_ready}, {m_out, m_locked, m_locked});
      end
    end
    total++;
    if (h0 != 8 || h1 != 8) begin bad++; $display("FAIL defaults_duty: got %0d/%0d want 8/8", h0, h1); end
  endtask

  task automatic test_config();
    int n, low, h1;
    wait_locked(n);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL config_wait: got locked=%b want 1", locked); end
    issue(1, 6, 2, 3);
    low = (locked === 1'b0) ? 1 : 0;
    h1 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge refclk);
      if (locked === 1'b0) low++;
      if (i >= 48) h1 += outclk[1];
      total++;
      if ({outclk, locked, cfg_ready} !== {m_out, m_locked, m_locked}) begin
        bad++; $display("FAIL config_model: cyc %0d got %b want %b", i, {outclk, locked, cfg_ready}, {m_out, m_locked, m_locked});
      end
    end
    total++;
    if (low != LOCK + 1) begin bad++; $display("FAIL config_unlock_len: got %0d want %0d", low, LOCK + 1); end
    total++;
    if (h1 != 4) begin bad++; $display("FAIL config_duty: got %0d want 4", h1); end
  endtask

  task automatic test_clamp();
    int n, h0;
    wait_locked(n);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL clamp_wait: got locked=%b want 1", locked); end
    issue(0, 1, 9, 7);
    h0 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge refclk);
      if (i >= 32) h0 += outclk[0];
      total++;
      if ({outclk, locked, cfg_ready} !== {m_out, m_locked, m_locked}) begin
        bad++; $display("FAIL clamp_model: cyc %0d got %b want %b", i, {outclk, locked, cfg_ready}, {m_out, m_locked, m_locked});
      end
    end
    total++;
    if (h0 != 4) begin bad++; $display("FAIL clamp_duty: got %0d want 4", h0); end
  endtask

  task automatic test_valid_held();
    int n, hs;
    wait_locked(n);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL held_wait: got locked=%b want 1", locked); end
    cfg_chan = 2'd1; cfg_div = 8'd5; cfg_high = 8'd1; cfg_phase = 8'd0;
    cfg_valid = 1'b1;
    hs = (cfg_ready === 1'b1) ? 1 : 0;
    for (int i = 1; i < 25; i++) begin
      @(negedge refclk);
      total++;
      if ({outclk, locked, cfg_ready} !== {m_out, m_locked, m_locked}) begin
        bad++; $display("FAIL held_model: cyc %0d got %b want %b", i, {outclk, locked, cfg_ready}, {m_out, m_locked, m_locked});
      end
      if (cfg_ready === 1'b1) hs++;
    end
    cfg_valid = 1'b0;
    total++;
    if (hs != 24 / (LOCK + 2) + 1) begin bad++; $display("FAIL held_handshakes: got %0d want %0d", hs, 24 / (LOCK + 2) + 1); end
    repeat (20) begin
      @(negedge refclk);
      total++;
      if ({outclk, locked, cfg_ready} !== {m_out, m_locked, m_locked}) begin
        bad++; $display("FAIL held_tail: got %b want %b", {outclk, locked, cfg_ready}, {m_out, m_locked, m_locked});
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, h0;
    // reset a few cycles after an update
    wait_locked(n);
    issue(0, 7, 3, 2);
    repeat (3) @(negedge refclk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({outclk, locked, cfg_ready} !== '0) begin bad++; $display("FAIL async_rst: got %b want 0", {outclk, locked, cfg_ready}); end
    @(negedge refclk);
    rst = 1'b0;
    n = 0;
    while (locked !== 1'b1 && n < 100) begin
      @(negedge refclk);
      n++;
      total++;
      if ({outclk, locked, cfg_ready} !== {m_out, m_locked, m_locked}) begin
        bad++; $display("FAIL rst_relock_model: got %b want %b", {outclk, locked, cfg_ready}, {m_out, m_locked, m_locked});
      end
    end
    total++;
    if (n != LOCK) begin bad++; $display("FAIL rst_relock_delay: got %0d want %0d", n, LOCK); end
    h0 = 0;
    repeat (16) begin
      @(negedge refclk);
      h0 += outclk[0];
    end
    total++;
    if (h0 != 8) begin bad++; $display("FAIL rst_default_duty: got %0d want 8", h0); end
    // reset landing inside the UPDATE cycle
    issue(1, 9, 4, 1);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({outclk, locked, cfg_ready} !== '0) begin bad++; $display("FAIL rst_in_update: got %b want 0", {outclk, locked, cfg_ready}); end
    @(negedge refclk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge refclk);
      total++;
      if ({outclk, locked, cfg_ready} !== {m_out, m_locked, m_locked}) begin
        bad++; $display("FAIL rst_update_model: got %b want %b", {outclk, locked, cfg_ready}, {m_out, m_locked, m_locked});
      end
    end
  endtask

  task automatic test_bad_chan();
    int n, h0;
    wait_locked(n);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL badchan_wait: got locked=%b want 1", locked); end
    issue(3, 9, 1, 1);
    h0 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge refclk);
      if (i >= 34) h0 += outclk[0];
      total++;
      if ({outclk, locked, cfg_ready} !== {m_out, m_locked, m_locked}) begin
        bad++; $display("FAIL badchan_model: cyc %0d got %b want %b", i, {outclk, locked, cfg_ready}, {m_out, m_locked, m_locked});
      end
    end
    total++;
    if (h0 != 8) begin bad++; $display("FAIL badchan_duty: got %0d want 8", h0); end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 8; it++) begin
      wait_locked(n);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL rand_wait: it %0d got locked=%b want 1", it, locked); end
      repeat ($urandom_range(0, 4)) begin
        @(negedge refclk);
        total++;
        if ({outclk, locked, cfg_ready} !== {m_out, m_locked, m_locked}) begin
          bad++; $display("FAIL rand_idle: got %b want %b", {outclk, locked, cfg_ready}, {m_out, m_locked, m_locked});
        end
      end
      issue($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12));
      repeat (3) begin
        cfg_valid = 1'b1;
        cfg_chan  = CW'($urandom_range(0, 3));
        cfg_div   = W'($urandom_range(0, 255));
        cfg_high  = W'($urandom_range(0, 255));
        cfg_phase = W'($urandom_range(0, 255));
        @(negedge refclk);
        total++;
        if ({outclk, locked, cfg_ready} !== {m_out, m_locked, m_locked}) begin
          bad++; $display("FAIL rand_noise: got %b want %b", {outclk, locked, cfg_ready}, {m_out, m_locked, m_locked});
        end
      end
      cfg_valid = 1'b0;
      repeat (25) begin
        @(negedge refclk);
        total++;
        if ({outclk, locked, cfg_ready} !== {m_out, m_locked, m_locked}) begin
          bad++; $display("FAIL rand_model: it %0d got %b want %b", it, {outclk, locked, cfg_ready}, {m_out, m_locked, m_locked});
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_defaults();
    test_config();
    test_clamp();
    test_valid_held();
    test_reset_mid();
    test_bad_chan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
